// File: rtl/common_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : common_types_pkg
//  Purpose  : Shared types for the memory subsystem: SRAM handshake status,
//             arbiter FSM states and arbiter port identifiers.
//  Revision : 1.0 - initial release with ram_arbiter types
// ============================================================================
package common_types_pkg;

  // Status reported by the SRAM and forwarded to each requester
  typedef enum logic [1:0] {
    RAM_IDLE = 2'd0,
    RAM_WAIT = 2'd1,
    RAM_DONE = 2'd2
  } ram_state_t;

  // Arbiter FSM: idle, or which port currently owns the SRAM
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IGRANT = 2'd1,
    ARB_DGRANT = 2'd2
  } arb_state_t;

  // Requester identity, used for round-robin history
  typedef enum logic {
    ARB_INSTR = 1'b0,
    ARB_DATA  = 1'b1
  } arb_port_t;

  localparam int WEN_W = 4;

  // The port that should win a tie, given the last port that was granted
  function automatic arb_port_t other_port(input arb_port_t p);
    return (p == ARB_INSTR) ? ARB_DATA : ARB_INSTR;
  endfunction

endpackage : common_types_pkg
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Shares one single-port SRAM between instruction fetch and data
//             access. One owner at a time, grant held until RAM_DONE or the
//             owner withdraws; ties resolved round-robin. Counts wait cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import common_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  // instruction fetch port
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_load,
  output ram_state_t        i_state,
  // data access port
  input  logic              d_ren,
  input  logic [WEN_W-1:0]  d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_store,
  output logic [DATA_W-1:0] d_load,
  output ram_state_t        d_state,
  // SRAM side
  output logic              m_ren,
  output logic [WEN_W-1:0]  m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_store,
  input  logic [DATA_W-1:0] m_load,
  input  ram_state_t        m_state,
  // performance counter
  output logic [31:0]       conflict_cnt
);

  logic       w_i_req;
  logic       w_d_req;
  logic       w_win_valid;
  arb_port_t  w_winner;
  logic       w_drive_i;
  logic       w_drive_d;
  logic       w_waiting;

  arb_state_t r_state;
  arb_port_t  r_last_grant;
  logic [31:0] r_conflict_cnt;

  assign w_i_req = i_ren;
  assign w_d_req = d_ren | (|d_wen);

  // Read data is shared; only the owner's status says whether it is valid
  assign i_load = m_load;
  assign d_load = m_load;

  assign conflict_cnt = r_conflict_cnt;

  // Round-robin winner for the idle state: sole requester, else the port not granted last
  always_comb begin
    w_win_valid = w_i_req | w_d_req;
    w_winner    = ARB_INSTR;
    if (w_i_req && w_d_req) begin
      w_winner = other_port(r_last_grant);
    end else if (w_d_req) begin
      w_winner = ARB_DATA;
    end
  end

  // Decide which port drives the SRAM this cycle; an owner that drops its request drives nothing
  always_comb begin
    w_drive_i = 1'b0;
    w_drive_d = 1'b0;
    if (nrst) begin
      unique case (r_state)
        ARB_IDLE: begin
          w_drive_i = w_win_valid && (w_winner == ARB_INSTR);
          w_drive_d = w_win_valid && (w_winner == ARB_DATA);
        end
        ARB_IGRANT: w_drive_i = w_i_req;
        ARB_DGRANT: w_drive_d = w_d_req;
        default: begin
          w_drive_i = 1'b0;
          w_drive_d = 1'b0;
        end
      endcase
    end
  end

  // Steer the driving port onto the SRAM; m_state never feeds this path
  always_comb begin
    m_ren   = 1'b0;
    m_wen   = '0;
    m_addr  = '0;
    m_store = '0;
    if (w_drive_i) begin
      m_ren  = i_ren;
      m_addr = i_addr;
    end else if (w_drive_d) begin
      m_ren   = d_ren;
      m_wen   = d_wen;
      m_addr  = d_addr;
      m_store = d_store;
    end
  end

  // Per-port status: owner mirrors the SRAM, any other requester is told to wait
  always_comb begin
    i_state = RAM_IDLE;
    d_state = RAM_IDLE;
    if (nrst) begin
      unique case (r_state)
        ARB_IGRANT: begin
          i_state = w_i_req ? m_state  : RAM_IDLE;
          d_state = w_d_req ? RAM_WAIT : RAM_IDLE;
        end
        ARB_DGRANT: begin
          i_state = w_i_req ? RAM_WAIT : RAM_IDLE;
          d_state = w_d_req ? m_state  : RAM_IDLE;
        end
        default: begin
          i_state = w_i_req ? RAM_WAIT : RAM_IDLE;
          d_state = w_d_req ? RAM_WAIT : RAM_IDLE;
        end
      endcase
    end
  end

  // Grant FSM: take a winner from idle, release on completion or withdrawal
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= ARB_INSTR;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_win_valid) begin
            r_state      <= (w_winner == ARB_INSTR) ? ARB_IGRANT : ARB_DGRANT;
            r_last_grant <= w_winner;
          end
        end
        ARB_IGRANT: begin
          if (!w_i_req || (m_state == RAM_DONE)) begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_DGRANT: begin
          if (!w_d_req || (m_state == RAM_DONE)) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // At most one port can be waiting in a given cycle, so a single increment suffices
  assign w_waiting = (w_i_req & ~w_drive_i) | (w_d_req & ~w_drive_d);

  // Saturating count of cycles in which a requester was held off
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_conflict_cnt <= '0;
    end else if (w_waiting && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

endmodule : ram_arbiter
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port SRAM between the core's instruction-fetch and data-access paths. It sits between the fetch and load/store units and the `sram` block. It grants one requester at a time and holds the grant until the memory reports RAM_DONE. Ties are resolved round-robin, so neither port starves. It also exposes a conflict counter for performance analysis.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports (reset nrst, synchronous, active-low; clock clk):
- clk  in  1  clock
- nrst  in  1  synchronous active-low reset
- i_ren  in  1  instruction read request
- i_addr  in  ADDR_W  instruction address
- i_load  out  DATA_W  instruction read data
- i_state  out  ram_state_t  instruction-port status
- d_ren  in  1  data read request
- d_wen  in  4  data byte write enables
- d_addr  in  ADDR_W  data address
- d_store  in  DATA_W  data write data
- d_load  out  DATA_W  data read data
- d_state  out  ram_state_t  data-port status
- m_ren  out  1  memory read enable
- m_wen  out  4  memory byte write enables
- m_addr  out  ADDR_W  memory address
- m_store  out  DATA_W  memory write data
- m_load  in  DATA_W  memory read data
- m_state  in  ram_state_t  memory status (RAM_IDLE/RAM_WAIT/RAM_DONE)
- conflict_cnt  out  32  cycles in which a requester waited on the other port's grant

## Operation
- Request definitions: instruction request = i_ren; data request = d_ren | (|d_wen).
- FSM states: ARB_IDLE, ARB_IGRANT, ARB_DGRANT.
- **ARB_IDLE**
  - Winner chosen combinationally: the sole requester; if both request, the port not in last_grant.
  - The winner's signals drive the m_* outputs in this same cycle.
  - Next state is the winner's GRANT state; last_grant <= winner.
  - With no request: m_ren=0, m_wen=0, stay in IDLE.
- **ARB_xGRANT**
  - The owner's ren/wen/addr/store pass through to the m_* outputs.
  - m_load fans out to both i_load and d_load.
  - Owner state = m_state.
- **Non-owner state**: RAM_WAIT if it is requesting, RAM_IDLE otherwise. In ARB_IDLE the losing requester likewise sees RAM_WAIT.
- **Completion**: m_state==RAM_DONE in a GRANT state moves the FSM to ARB_IDLE next cycle. The owner sees RAM_DONE for exactly that cycle.
- **Abort**: if the owner drops its request while in GRANT, the FSM returns to ARB_IDLE next cycle. m_* outputs are deasserted that cycle and no DONE is reported.
- **Request hold**: requesters hold addr/store/wen stable until they see RAM_DONE. The arbiter does not latch them.
- **Instruction port**: never writes; the m_wen source for the instruction port is 4'b0.
- **conflict_cnt**: +1 on every cycle in which a requester is requesting and is not the current driver of m_*. Saturates at 2^32-1.

## Timing
- Reset values:
  - FSM = ARB_IDLE
  - last_grant = INSTR, so data wins the first tie
  - conflict_cnt = 0
  - m_ren = 0, m_wen = 0
  - i_state = d_state = RAM_IDLE
- Reset mid-grant aborts the transaction; the SRAM is reset by the same nrst.
- Arbiter adds zero cycles to a lone access. With SRAM LAT=0:
  - Request at cycle 0, RAM_DONE at cycle 1.
  - The FSM is back in IDLE at cycle 2.
  - A back-to-back request from the same port restarts at cycle 2.
- Both ports requesting continuously alternate grants: D, I, D, I.
- A request arriving while the other port owns the memory waits at least until the cycle after RAM_DONE.
- No combinational path from m_state to m_* except through the FSM state register. The m_* outputs depend on the FSM state and the requester inputs only.

## Structure
- Add `arb_state_t` (ARB_IDLE, ARB_IGRANT, ARB_DGRANT) and `arb_port_t` (ARB_INSTR, ARB_DATA) to `common_types_pkg`, alongside the existing `ram_state_t`.
- Single module, no sub-modules. Round-robin selection stays inline (two requesters).
- Instantiated in the top level between the fetch/LSU interfaces and `sram`, with a ram_if on the memory side.

## Test plan
- Lone instruction read at addr 0x0000_0100, SRAM LAT=0 -> m_ren=1, m_addr=0x100 at cycle 0; i_state=RAM_DONE at cycle 1 with i_load = memory word; d_state=RAM_IDLE throughout.
- Simultaneous i_ren and d_wen=4'hF (addr 0x200, store 0xDEADBEEF) right after reset -> data granted first, write completes at cycle 1; instruction granted at cycle 2, RAM_DONE at cycle 3; conflict_cnt=2.
- Both ports requesting continuously for 8 accesses with LAT=2 -> grants alternate D, I, D, I…; each DONE lasts one cycle; no DONE ever reaches the non-owner.
- Byte write d_wen=4'b0010 to 0x300 followed by a read of 0x300 -> only bits [15:8] change, and the readback matches.
- Owner drops d_ren mid-wait (LAT=3) -> FSM returns to IDLE next cycle, no RAM_DONE to the data port; a pending i_ren is granted the following cycle.
- nrst asserted during ARB_IGRANT -> next cycle FSM=ARB_IDLE, conflict_cnt=0, m_ren=0, both states RAM_IDLE.
